// File: rtl/seq_mac_pkg.sv
// Shared definitions for the sequential digit multiply-accumulate unit.
//   state_e         : controller state encoding (IDLE, RUN, DONE)
//   cnt_width()     : bit width of a digit counter that must reach K-1
//   params_ok()     : legality of the W / D / ACC_W combination
package seq_mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-digit operand still needs a one-bit counter.
  function automatic int cnt_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  function automatic bit params_ok(input int w, input int d, input int acc_w);
    return (d > 0) && (w % d == 0) && (acc_w >= 2 * w);
  endfunction

endpackage

// File: rtl/seq_digit_mac_digit_mult.sv
// Combinational unsigned DxD -> 2D digit multiplier.
//   x_i : D-bit digit of the multiplicand
//   y_i : D-bit digit of the multiplier
//   p_o : 2D-bit product
module digit_mult #(
  parameter int D = 2
) (
  input  logic [D-1:0]   x_i,
  input  logic [D-1:0]   y_i,
  output logic [2*D-1:0] p_o
);

  assign p_o = {{D{1'b0}}, x_i} * {{D{1'b0}}, y_i};

endmodule

// File: rtl/seq_digit_mac.sv
// Sequential unsigned multiply-accumulate: one digit pair per cycle through a
// single DxD multiplier, shifted into place and added to the accumulator.
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   start, acc_en : operation request; acc_en=1 adds to acc, 0 replaces it
//   a, b          : operands, captured when start is accepted in IDLE
//   busy, done    : busy while not IDLE; done pulses when acc is final
//   acc, ovf      : accumulator and sticky carry-out flag
//
// state | meaning
// IDLE  | waiting for start; acc/ovf held
// RUN   | adding one digit-pair product per cycle, K*K cycles
// DONE  | acc holds the final result for one cycle, done=1
module seq_digit_mac
  import seq_mac_pkg::*;
#(
  parameter int W     = 8,
  parameter int D     = 2,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             acc_en,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  localparam int K  = W / D;
  localparam int CW = cnt_width(K);

  if (!params_ok(W, D, ACC_W)) begin : g_bad_params
    $error("seq_digit_mac: W must be a multiple of D and ACC_W >= 2*W");
  end

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [CW-1:0]    i_q, i_d, j_q, j_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic [D-1:0]     a_dig, b_dig;
  logic [2*D-1:0]   prod;
  logic [CW:0]      dig_sum;
  logic [ACC_W-1:0] addend;
  logic [ACC_W:0]   sum_ext;

  assign a_dig = a_q[i_q*D +: D];
  assign b_dig = b_q[j_q*D +: D];

  digit_mult #(.D(D)) u_digit_mult (
    .x_i (a_dig),
    .y_i (b_dig),
    .p_o (prod)
  );

  // Shift never exceeds 2W-2D, so the product always fits inside ACC_W bits;
  // only the accumulation can carry out of the top bit.
  assign dig_sum = {1'b0, i_q} + {1'b0, j_q};
  assign addend  = ACC_W'(prod) << (dig_sum * D);
  assign sum_ext = {1'b0, acc_q} + {1'b0, addend};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          i_d     = '0;
          j_d     = '0;
          if (!acc_en) begin
            acc_d = '0;
            ovf_d = 1'b0;
          end
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = sum_ext[ACC_W-1:0];
        ovf_d = ovf_q | sum_ext[ACC_W];
        if (j_q == CW'(K - 1)) begin
          j_d = '0;
          if (i_q == CW'(K - 1)) state_d = DONE;
          else                   i_d = i_q + CW'(1);
        end else begin
          j_d = j_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign acc  = acc_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_digit_mac.sv
// Self-checking bench for seq_digit_mac (W=8, D=2, ACC_W=20). Results are
// compared against a plain-arithmetic accumulate model.
module tb_seq_digit_mac;

  localparam int W     = 8;
  localparam int D     = 2;
  localparam int ACC_W = 20;
  localparam int N     = (W / D) * (W / D);

  logic             clk = 1'b0;
  logic             rst, start, acc_en;
  logic [W-1:0]     a, b;
  logic             busy, done, ovf;
  logic [ACC_W-1:0] acc;

  int     nvec = 0;
  int     nerr = 0;
  longint m_acc = 0;
  bit     m_ovf = 1'b0;

  always #5 clk = ~clk;

  seq_digit_mac #(.W(W), .D(D), .ACC_W(ACC_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .acc_en (acc_en),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .acc    (acc),
    .ovf    (ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: integer accumulate modulo 2^ACC_W, sticky flag on wrap.
  task automatic model_op(input int op_a, input int op_b, input bit en);
    if (!en) begin
      m_acc = 0;
      m_ovf = 1'b0;
    end
    m_acc = m_acc + longint'(op_a) * longint'(op_b);
    if (m_acc >= (longint'(1) << ACC_W)) begin
      m_ovf = 1'b1;
      m_acc = m_acc - (longint'(1) << ACC_W);
    end
  endtask

  // Starts an op from an IDLE cycle; with hold=1 start stays high and the
  // operand inputs are scrambled every cycle while the op runs.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic en, input bit hold, input string tag);
    int busy_cyc;
    bit seen;
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    a = op_a; b = op_b; acc_en = en; start = 1'b1;
    @(posedge clk);
    model_op(int'(op_a), int'(op_b), en);
    seen = 1'b0;
    busy_cyc = 0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        seen = 1'b1;
        chk({tag, "_latency"}, cyc, N + 1);
      end else if (hold) begin
        start  = 1'b1;
        a      = W'($urandom);
        b      = W'($urandom);
        acc_en = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    if (!seen) chk({tag, "_done_timeout"}, 0, 1);
    chk({tag, "_busy_cycles"}, busy_cyc, N + 1);
    chk({tag, "_acc"}, acc, m_acc);
    chk({tag, "_ovf"}, ovf, m_ovf);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; acc_en = 1'b0; a = '0; b = '0;
    #12;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_acc",  acc,  0);
    chk("reset_ovf",  ovf,  1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_op(8'd13, 8'd11, 1'b0, 1'b0, "basic");
    chk("basic_const", acc, 143);

    run_op(8'hC0, 8'h03, 1'b0, 1'b0, "digit");
    chk("digit_const", acc, 576);

    run_op(8'd255, 8'd255, 1'b0, 1'b0, "acc_first");
    chk("acc_first_const", acc, 65025);
    run_op(8'd255, 8'd255, 1'b1, 1'b0, "acc_second");
    chk("acc_second_const", acc, 130050);
    chk("acc_second_ovf", ovf, 1'b0);

    run_op(8'd255, 8'd255, 1'b0, 1'b0, "ovf_seed");
    for (int k = 0; k < 16; k++) run_op(8'd255, 8'd255, 1'b1, 1'b0, "ovf_chain");
    chk("ovf_chain_const", acc, 56849);
    chk("ovf_chain_flag",  ovf, 1'b1);

    // Abort an accumulating op while ovf is set and acc is nonzero.
    @(negedge clk);
    a = 8'd100; b = 8'd100; acc_en = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_acc",  acc,  0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_ovf",  ovf,  1'b0);
    m_acc = 0;
    m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op(8'd0, 8'd200, 1'b0, 1'b0, "after_rst");
    chk("after_rst_const", acc, 0);

    run_op(8'd2, 8'd3, 1'b0, 1'b0, "ovf_clear");
    chk("ovf_clear_const", acc, 6);
    chk("ovf_clear_flag",  ovf, 1'b0);

    run_op(W'($urandom), W'($urandom), 1'b0, 1'b1, "hold");
    @(negedge clk);
    chk("hold_single_done", done, 1'b0);
    chk("hold_idle_busy",   busy, 1'b0);
    chk("hold_acc_held",    acc,  m_acc);
    start = 1'b0;

    // Consecutive calls start in the IDLE cycle right after done.
    run_op(8'd7, 8'd9, 1'b1, 1'b0, "b2b_a");
    run_op(8'd250, 8'd17, 1'b1, 1'b0, "b2b_b");

    for (int k = 0; k < 20; k++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, "rand");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/seq_digit_mac.md
Name: seq_digit_mac

Overview:
Parametrised sequential unsigned multiply-accumulate unit. Computes a*b one digit-pair per cycle with a single DxD digit multiplier and a shift-add accumulator. The product is either loaded into the accumulator or added to its current value. This is the general-width successor of our fixed 4x4 digit-serial multiplier, and the building block for the complex-MAC datapath. It adds an accumulate mode, a sticky overflow flag and a busy/done handshake.

Parameters:
W, 8, operand width in bits; must be a multiple of D.
D, 2, digit width in bits.
ACC_W, 20, accumulator width; must be >= 2*W.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request a new operation; sampled only in IDLE.
acc_en  input  1  sampled with start; 1 = add product to acc, 0 = replace acc with product.
a  input  W  multiplicand; sampled with start.
b  input  W  multiplier; sampled with start.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse when acc holds the final result.
acc  output  ACC_W  accumulator value, registered.
ovf  output  1  sticky overflow: a carry out of bit ACC_W-1 occurred since the last non-accumulating start.

Behaviour:
- Clock and reset: clock clk; reset rst, asynchronous, active-high.
- On reset: state=IDLE; acc=0, ovf=0, busy=0, done=0; operand registers and digit counters = 0.
- Reset mid-operation aborts immediately with the same values; no done is produced.
- Definitions: K=W/D; N=K*K.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge t:
  - latch a and b.
  - i=0, j=0.
  - if acc_en=0: acc<=0 and ovf<=0; otherwise acc and ovf hold.
  - go to RUN.
- IDLE, start=0: hold all state.
- RUN, each edge:
  - p = a_reg[i*D +: D] * b_reg[j*D +: D], 2D bits, from the digit multiplier.
  - acc <= acc + (p << ((i+j)*D)), computed modulo 2^ACC_W.
  - ovf <= ovf | carry-out of that addition.
  - j increments; when j wraps from K-1 to 0, i increments.
  - After the pair (K-1,K-1) is added, go to DONE.
- Latency: RUN lasts exactly N cycles. done=1 in the cycle after edge t+N, then the block returns to IDLE on the next edge.
  - A start sampled in that IDLE cycle is accepted, giving back-to-back throughput of one op per N+2 cycles.
- start in RUN or DONE is ignored; it is not queued.
- Changes to a, b or acc_en after acceptance have no effect on the running operation.
- acc holds its value in IDLE and DONE; it changes only in RUN and on an accepted start with acc_en=0.
- acc updates during RUN; acc is valid only when done=1 or in IDLE afterwards.
- Zero operands still take the full N cycles; there is no early exit.
- Width rules: shift amounts reach at most 2W-2D, so the shifted product fits in 2W <= ACC_W bits and zero-extends into the adder. Only the accumulation itself can overflow.

Decomposition:
- Shared package seq_mac_pkg:
  - state enum {IDLE, RUN, DONE}, 2 bits.
  - function computing counter width $clog2(K) (minimum 1).
  - elaboration-time checks: W%D==0 and ACC_W>=2W.
- Sub-module digit_mult: combinational DxD -> 2D unsigned multiplier, parametrised by D.
- Top module contains:
  - FSM;
  - i/j counters;
  - digit selection muxes;
  - shifter, adder and accumulator register.

Test Plan:
(W=8, D=2, ACC_W=20, N=16)
- Basic multiply: a=13, b=11, acc_en=0, start pulse -> busy for 17 cycles; done exactly 16 cycles after the start edge; acc=143; ovf=0.
- Accumulate: 255*255 with acc_en=0 -> acc=65025; then 255*255 with acc_en=1 -> acc=130050, ovf=0.
- Overflow: 255*255 with acc_en=0, then 16 more ops with acc_en=1 -> acc=56849 (1105425 mod 2^20), ovf=1. The next op with acc_en=0 and a=2, b=3 -> acc=6, ovf=0.
- Handshake robustness: start held high and a/b changed every cycle during RUN -> exactly one done; result equals the product of the values sampled at acceptance. Start in the IDLE cycle right after done is accepted.
- Reset mid-run: rst asserted at RUN cycle 5 -> same cycle acc=0, busy=0, done=0, ovf=0. A following op a=0, b=200 -> done after 16 cycles, acc=0.
- Digit coverage: a=8'hC0, b=8'h03 (only top and bottom digits nonzero) -> acc=576; confirms shift (i+j)*D indexing.
